// File: rtl/lock_ctrl_param_if.sv
// lock_ctrl_param_if: bus between the keypad debouncers, lock_ctrl_param and the display logic.
//   master: drives the keypad pulses and admin controls, observes the lock status.
//   slave : the lock controller (receives the keypad pulses, drives the status).
//   Inputs : digit_in[3:0], digit_load, ok, admin_mode, admin_clear
//   Outputs: entry[4*NUM_DIGITS-1:0], entry_cnt, state[1:0], err_cnt[3:0], unlocked, alarm, leds[3:0]
interface lock_ctrl_param_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned EntryW = 4 * NUM_DIGITS;
    localparam int unsigned CntW   = $clog2(NUM_DIGITS + 1);

    logic [3:0]        digit_in;
    logic              digit_load;
    logic              ok;
    logic              admin_mode;
    logic              admin_clear;
    logic [EntryW-1:0] entry;
    logic [CntW-1:0]   entry_cnt;
    logic [1:0]        state;
    logic [3:0]        err_cnt;
    logic              unlocked;
    logic              alarm;
    logic [3:0]        leds;

    modport master (
        output digit_in, digit_load, ok, admin_mode, admin_clear,
        input  entry, entry_cnt, state, err_cnt, unlocked, alarm, leds
    );

    modport slave (
        input  digit_in, digit_load, ok, admin_mode, admin_clear,
        output entry, entry_cnt, state, err_cnt, unlocked, alarm, leds
    );
endinterface

// File: rtl/lock_ctrl_param.sv
// lock_ctrl_param: parametrised keypad-lock controller (digit entry with backspace, password
// check, retry limit with alarm, edit/unlock timeouts, admin password write).
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - lock_ctrl_param_if.slave: keypad pulses in, entry/state/err_cnt/unlocked/alarm/leds out
// Optional feature: define ALARM_BLINK_EN to blink leds in ALARM with half-period BLINK_CYC.
module lock_ctrl_param #(
    parameter int unsigned               NUM_DIGITS         = 4,
    parameter int unsigned               MAX_TRIES          = 3,
    parameter int unsigned               EDIT_TIMEOUT_CYC   = 500_000_000,
    parameter int unsigned               UNLOCK_TIMEOUT_CYC = 1_000_000_000,
    parameter logic [4*NUM_DIGITS-1:0]   DEFAULT_PSWD       = '0,
    parameter int unsigned               BLINK_CYC          = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    lock_ctrl_param_if.slave bus
);
    localparam int unsigned EntryW = 4 * NUM_DIGITS;
    localparam int unsigned CntW   = $clog2(NUM_DIGITS + 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || MAX_TRIES < 1 || MAX_TRIES > 15 ||
        EDIT_TIMEOUT_CYC == 0 || UNLOCK_TIMEOUT_CYC == 0 || BLINK_CYC == 0) begin : g_param_err
        $error("lock_ctrl_param: parameter out of range");
    end

    typedef enum logic [1:0] {StWait = 2'b00, StEdit = 2'b01, StUnlocked = 2'b10, StAlarm = 2'b11}
        state_e;

    state_e            state_q, state_d;
    logic [EntryW-1:0] entry_q, entry_d, pswd_q, pswd_d, ld_entry;
    logic [CntW-1:0]   cnt_q, cnt_d, ld_cnt;
    logic [3:0]        err_q, err_d, err_inc;
    logic [31:0]       tmr_q, tmr_d;
    logic              full, ok_eff, dl_eff;
    logic [3:0]        alarm_leds;

    always_comb begin
        full    = (cnt_q == CntW'(NUM_DIGITS));
        err_inc = (err_q == 4'hF) ? 4'hF : err_q + 4'd1;
        // Priority admin_clear > ok > digit_load; lower pulses in the same cycle are dropped.
        ok_eff  = bus.ok & ~bus.admin_clear;
        dl_eff  = bus.digit_load & ~bus.ok & ~bus.admin_clear;

        // Result of applying digit_in to the entry register (digit shift-in or backspace).
        ld_entry = entry_q;
        ld_cnt   = cnt_q;
        if (bus.digit_in <= 4'd9) begin
            ld_entry = EntryW'({entry_q, bus.digit_in});
            ld_cnt   = full ? cnt_q : cnt_q + CntW'(1);
        end else if (cnt_q != '0) begin
            ld_entry = entry_q >> 4;
            ld_cnt   = cnt_q - CntW'(1);
        end

        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pswd_d  = pswd_q;
        tmr_d   = tmr_q;

        if (bus.admin_clear) begin
            err_d = '0;
        end

        unique case (state_q)
            StWait: begin
                if (dl_eff) begin
                    entry_d = ld_entry;
                    cnt_d   = ld_cnt;
                    state_d = StEdit;
                end
            end
            StEdit: begin
                if (ok_eff) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    if (bus.admin_mode) begin
                        if (full) pswd_d = entry_q;
                        state_d = StWait;
                    end else if (full && entry_q == pswd_q) begin
                        err_d   = '0;
                        state_d = StUnlocked;
                    end else begin
                        err_d   = err_inc;
                        state_d = (err_inc == 4'(MAX_TRIES)) ? StAlarm : StWait;
                    end
                end else if (dl_eff) begin
                    entry_d = ld_entry;
                    cnt_d   = ld_cnt;
                    tmr_d   = '0;
                end else if (tmr_q == 32'(EDIT_TIMEOUT_CYC - 1)) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            StUnlocked: begin
                if (ok_eff || tmr_q == 32'(UNLOCK_TIMEOUT_CYC - 1)) begin
                    state_d = StWait;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            StAlarm: begin
                if (bus.admin_clear) state_d = StWait;
            end
        endcase

        // One shared timer: every state change restarts it.
        if (state_d != state_q) tmr_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWait;
            entry_q <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            pswd_q  <= DEFAULT_PSWD;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pswd_q  <= pswd_d;
            tmr_q   <= tmr_d;
        end
    end

`ifdef ALARM_BLINK_EN
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_off_q, blink_off_d;

    always_comb begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (state_q == StAlarm) begin
            blink_off_d = blink_off_q;
            if (blink_cnt_q == 32'(BLINK_CYC - 1)) begin
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 32'd1;
            end
        end
        alarm_leds = blink_off_q ? 4'b0000 : 4'b1111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end
`else
    assign alarm_leds = 4'b1111;
`endif

    always_comb begin
        bus.leds = 4'b0001;
        unique case (state_q)
            StWait:     bus.leds = 4'b0001;
            StEdit:     bus.leds = 4'b0011;
            StUnlocked: bus.leds = 4'b1111;
            StAlarm:    bus.leds = alarm_leds;
        endcase
    end

    assign bus.entry     = entry_q;
    assign bus.entry_cnt = cnt_q;
    assign bus.state     = state_q;
    assign bus.err_cnt   = err_q;
    assign bus.unlocked  = (state_q == StUnlocked);
    assign bus.alarm     = (state_q == StAlarm);
endmodule

// File: tb/tb_lock_ctrl_param.sv
// tb_lock_ctrl_param: table-driven directed bench for lock_ctrl_param plus hand-written
// sequences for timeouts, asynchronous reset and the alarm led pattern.
module tb_lock_ctrl_param;
    localparam int unsigned ND = 4;
    localparam logic [1:0] W = 2'd0, E = 2'd1, U = 2'd2, A = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lock_ctrl_param_if #(.NUM_DIGITS(ND)) bus ();

    lock_ctrl_param #(
        .NUM_DIGITS        (ND),
        .MAX_TRIES         (3),
        .EDIT_TIMEOUT_CYC  (100),
        .UNLOCK_TIMEOUT_CYC(200),
        .DEFAULT_PSWD      (16'h1234),
        .BLINK_CYC         (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]  d;
        logic        dl;
        logic        ok;
        logic        adm;
        logic        aclr;
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic [1:0]  st;
        logic [3:0]  err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic [3:0] d, input logic dl, input logic ok,
                                input logic adm, input logic aclr, input logic [15:0] entry,
                                input logic [2:0] cnt, input logic [1:0] st,
                                input logic [3:0] err);
        vec_t v;
        v.d = d; v.dl = dl; v.ok = ok; v.adm = adm; v.aclr = aclr;
        v.entry = entry; v.cnt = cnt; v.st = st; v.err = err;
        vecs.push_back(v);
    endfunction

    function automatic logic [3:0] leds_of(input logic [1:0] st);
        case (st)
            W:       return 4'b0001;
            E:       return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] entry, input logic [2:0] cnt,
                             input logic [1:0] st, input logic [3:0] err);
        check({tag, ".entry"}, 32'(bus.entry), 32'(entry));
        check({tag, ".entry_cnt"}, 32'(bus.entry_cnt), 32'(cnt));
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(err));
        check({tag, ".unlocked"}, 32'(bus.unlocked), 32'(st == U));
        check({tag, ".alarm"}, 32'(bus.alarm), 32'(st == A));
        check({tag, ".leds"}, 32'(bus.leds), 32'(leds_of(st)));
    endtask

    // Inputs change at posedge+1; one edge samples them; outputs sampled at the next posedge+1.
    task automatic step(input logic [3:0] d, input logic dl, input logic ok, input logic adm,
                        input logic aclr);
        bus.digit_in    = d;
        bus.digit_load  = dl;
        bus.ok          = ok;
        bus.admin_mode  = adm;
        bus.admin_clear = aclr;
        @(posedge clk);
        #1;
        bus.digit_load  = 1'b0;
        bus.ok          = 1'b0;
        bus.admin_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) step(code[4*i+:4], 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.digit_in = '0; bus.digit_load = 1'b0; bus.ok = 1'b0;
        bus.admin_mode = 1'b0; bus.admin_clear = 1'b0;

        // Correct default code, then relock with ok.
        add(1, 1, 0, 0, 0, 16'h0001, 1, E, 0);
        add(2, 1, 0, 0, 0, 16'h0012, 2, E, 0);
        add(3, 1, 0, 0, 0, 16'h0123, 3, E, 0);
        add(4, 1, 0, 0, 0, 16'h1234, 4, E, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 0, U, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 0, W, 0);
        // Backspace and overflow.
        add(5, 1, 0, 0, 0, 16'h0005, 1, E, 0);
        add(6, 1, 0, 0, 0, 16'h0056, 2, E, 0);
        add(15, 1, 0, 0, 0, 16'h0005, 1, E, 0);
        add(7, 1, 0, 0, 0, 16'h0057, 2, E, 0);
        add(1, 1, 0, 0, 0, 16'h0571, 3, E, 0);
        add(2, 1, 0, 0, 0, 16'h5712, 4, E, 0);
        add(3, 1, 0, 0, 0, 16'h7123, 4, E, 0);
        add(10, 1, 0, 0, 0, 16'h0712, 3, E, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 0, W, 1);   // short entry is a mismatch
        add(0, 0, 0, 0, 1, 16'h0000, 0, W, 0);   // admin_clear outside ALARM
        // Three wrong codes -> ALARM.
        for (int k = 1; k <= 3; k++) begin
            add(9, 1, 0, 0, 0, 16'h0009, 1, E, 4'(k - 1));
            add(9, 1, 0, 0, 0, 16'h0099, 2, E, 4'(k - 1));
            add(9, 1, 0, 0, 0, 16'h0999, 3, E, 4'(k - 1));
            add(9, 1, 0, 0, 0, 16'h9999, 4, E, 4'(k - 1));
            add(0, 0, 1, 0, 0, 16'h0000, 0, (k == 3) ? A : W, 4'(k));
        end
        add(0, 0, 1, 0, 0, 16'h0000, 0, A, 3);
        add(5, 1, 0, 0, 0, 16'h0000, 0, A, 3);
        add(0, 0, 1, 0, 1, 16'h0000, 0, W, 0);   // admin_clear + ok in ALARM
        // Admin write 4321, then a short admin write that must not change it.
        add(4, 1, 0, 1, 0, 16'h0004, 1, E, 0);
        add(3, 1, 0, 1, 0, 16'h0043, 2, E, 0);
        add(2, 1, 0, 1, 0, 16'h0432, 3, E, 0);
        add(1, 1, 0, 1, 0, 16'h4321, 4, E, 0);
        add(0, 0, 1, 1, 0, 16'h0000, 0, W, 0);
        add(7, 1, 0, 1, 0, 16'h0007, 1, E, 0);
        add(0, 0, 1, 1, 0, 16'h0000, 0, W, 0);
        // Old code now fails, new code unlocks.
        add(1, 1, 0, 0, 0, 16'h0001, 1, E, 0);
        add(2, 1, 0, 0, 0, 16'h0012, 2, E, 0);
        add(3, 1, 0, 0, 0, 16'h0123, 3, E, 0);
        add(4, 1, 0, 0, 0, 16'h1234, 4, E, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 0, W, 1);
        add(4, 1, 0, 0, 0, 16'h0004, 1, E, 1);
        add(3, 1, 0, 0, 0, 16'h0043, 2, E, 1);
        add(2, 1, 0, 0, 0, 16'h0432, 3, E, 1);
        add(1, 1, 0, 0, 0, 16'h4321, 4, E, 1);
        add(0, 0, 1, 0, 0, 16'h0000, 0, U, 0);
        add(8, 1, 0, 0, 0, 16'h0000, 0, U, 0);   // digit ignored in UNLOCKED
        add(0, 0, 1, 0, 0, 16'h0000, 0, W, 0);
        // ok + digit_load together: digit dropped, check uses 4321.
        add(4, 1, 0, 0, 0, 16'h0004, 1, E, 0);
        add(3, 1, 0, 0, 0, 16'h0043, 2, E, 0);
        add(2, 1, 0, 0, 0, 16'h0432, 3, E, 0);
        add(1, 1, 0, 0, 0, 16'h4321, 4, E, 0);
        add(9, 1, 1, 0, 0, 16'h0000, 0, U, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 0, W, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 0, W, 0);   // ok ignored in WAIT
        add(12, 1, 0, 0, 0, 16'h0000, 0, E, 0);  // backspace at count 0 still enters EDIT
        add(0, 0, 1, 0, 0, 16'h0000, 0, W, 1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 16'h0000, 0, W, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset", 16'h0000, 0, W, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].d, vecs[i].dl, vecs[i].ok, vecs[i].adm, vecs[i].aclr);
            check_all($sformatf("vec%0d", i), vecs[i].entry, vecs[i].cnt, vecs[i].st,
                      vecs[i].err);
        end

        // Unlock timeout: still UNLOCKED after 199 idle cycles, WAIT after 200.
        load_code(16'h4321);
        step(0, 0, 1, 0, 0);
        check_all("unl_enter", 16'h0000, 0, U, 0);
        idle(199);
        check_all("unl_199", 16'h0000, 0, U, 0);
        idle(1);
        check_all("unl_200", 16'h0000, 0, W, 0);

        // Edit timeout with a restart at cycle 99; err_cnt must survive the timeout.
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check_all("edt_err", 16'h0000, 0, W, 1);
        step(1, 1, 0, 0, 0);
        idle(98);
        check_all("edt_98", 16'h0001, 1, E, 1);
        step(2, 1, 0, 0, 0);
        idle(99);
        check_all("edt_restart", 16'h0012, 2, E, 1);
        idle(1);
        check_all("edt_timeout", 16'h0000, 0, W, 1);

        // Asynchronous reset mid-entry; stored password must return to 1234.
        step(5, 1, 0, 0, 0);
        step(6, 1, 0, 0, 0);
        check_all("pre_rst", 16'h0056, 2, E, 1);
        #3 rst_n = 1'b0;
        #1;
        check_all("async_rst", 16'h0000, 0, W, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_code(16'h1234);
        step(0, 0, 1, 0, 0);
        check_all("pswd_default", 16'h0000, 0, U, 0);
        step(0, 0, 1, 0, 0);

        // Alarm leds pattern.
        for (int k = 0; k < 3; k++) begin
            load_code(16'h9999);
            step(0, 0, 1, 0, 0);
        end
        check_all("alm_enter", 16'h0000, 0, A, 3);
        idle(9);
        check("alm_leds_9", 32'(bus.leds), 32'hF);
        idle(1);
`ifdef ALARM_BLINK_EN
        check("alm_leds_10", 32'(bus.leds), 32'h0);
`else
        check("alm_leds_10", 32'(bus.leds), 32'hF);
`endif
        idle(10);
        check("alm_leds_20", 32'(bus.leds), 32'hF);
        check("alm_hold", 32'(bus.state), 32'(A));
        step(0, 0, 0, 0, 1);
        check_all("alm_clear", 16'h0000, 0, W, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
